np_hvc_iter: RTL and testbench



---
 rtl/np_hvc_iter.sv | 166 ++++++++++++++++
 tb/tb_np_hvc_iter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/np_hvc_iter.sv
// Iterative hyperbolic CORDIC in vectoring mode: y -> 0, z += atanh(y0/x0), x -> K_h*sqrt(x0^2-y0^2).
// Optional gain compensation of x_out is enabled by defining HVC_GAIN_COMP_EN (adds a COMP cycle).
module np_hvc_iter #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int N_ITER     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] y_in,
    input  logic signed [DATA_WIDTH-1:0] z_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] x_out,
    output logic signed [DATA_WIDTH-1:0] y_out,
    output logic signed [DATA_WIDTH-1:0] z_out,
    output logic                         err_out
);
    localparam int SW = $clog2(N_ITER + 1);
    localparam logic [SW-1:0] LAST = SW'(N_ITER);

    typedef enum logic [1:0] {IDLE, ITER, COMP, DONE} state_t;

    // atanh(2^-i) by its odd power series at 2^-60 scale, then rounded to FRAC_BITS.
    function automatic logic [63:0] atanh_fx(input int i);
        logic [63:0] acc;
        acc = '0;
        for (int k = 0; k < 40; k++) begin
            int e;
            e = 60 - i * (2 * k + 1);
            if (e >= 0) acc = acc + ((64'd1 << e) / 64'(2 * k + 1));
        end
        return (acc + (64'd1 << (59 - FRAC_BITS))) >> (60 - FRAC_BITS);
    endfunction

    logic signed [DATA_WIDTH-1:0] atanh_tab [0:N_ITER];
    assign atanh_tab[0] = '0;
    for (genvar g = 1; g <= N_ITER; g++) begin : g_tab
        localparam logic [63:0] V = atanh_fx(g);
        assign atanh_tab[g] = V[DATA_WIDTH-1:0];
    end

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] x, y, z;
    logic        [SW-1:0]         i;
    logic                         rep;

    // Range check done one bit wider so |y| of the most negative word does not wrap.
    logic signed [DATA_WIDTH:0] xe, ye;
    logic                       in_err;
    always_comb begin
        xe     = {x_in[DATA_WIDTH-1], x_in};
        ye     = {y_in[DATA_WIDTH-1], y_in};
        in_err = xe[DATA_WIDTH] || (xe == '0) || (ye >= xe) || (-ye >= xe);
    end

    logic signed [DATA_WIDTH-1:0] xsh, ysh, xn, yn, zn;
    logic                         need_rep;
    always_comb begin
        xsh = x >>> i;
        ysh = y >>> i;
        if (!y[DATA_WIDTH-1]) begin
            xn = x - ysh;
            yn = y - xsh;
            zn = z + atanh_tab[i];
        end else begin
            xn = x + ysh;
            yn = y + xsh;
            zn = z - atanh_tab[i];
        end
        need_rep = !rep && ((i == SW'(4)) || ((N_ITER >= 13) && (i == SW'(13))));
    end

`ifdef HVC_GAIN_COMP_EN
    // Floor of 2^FRAC_BITS / K_h, 79134 at 16 fractional bits.
    localparam longint KINV = longint'($floor((2.0 ** FRAC_BITS) / 0.8281593609602));
    localparam logic signed [2*DATA_WIDTH-1:0] KINV_W = (2*DATA_WIDTH)'(KINV);
    logic signed [2*DATA_WIDTH-1:0] prod;
    assign prod = $signed((2*DATA_WIDTH)'(x)) * KINV_W;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            err_out   <= 1'b0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= SW'(1);
            rep       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x        <= x_in;
                        y        <= y_in;
                        z        <= z_in;
                        i        <= SW'(1);
                        rep      <= 1'b0;
                        in_ready <= 1'b0;
                        if (in_err) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            x_out     <= '0;
                            y_out     <= '0;
                            z_out     <= '0;
                            err_out   <= 1'b1;
                        end else begin
                            state   <= ITER;
                            err_out <= 1'b0;
                        end
                    end
                end
                ITER: begin
                    x <= xn;
                    y <= yn;
                    z <= zn;
                    if (need_rep) begin
                        rep <= 1'b1;
                    end else begin
                        rep <= 1'b0;
                        if (i == LAST) begin
`ifdef HVC_GAIN_COMP_EN
                            state <= COMP;
`else
                            state     <= DONE;
                            out_valid <= 1'b1;
                            x_out     <= xn;
                            y_out     <= yn;
                            z_out     <= zn;
`endif
                        end else begin
                            i <= i + 1'b1;
                        end
                    end
                end
`ifdef HVC_GAIN_COMP_EN
                COMP: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                    x_out     <= prod[FRAC_BITS +: DATA_WIDTH];
                    y_out     <= y;
                    z_out     <= z;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        i         <= SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_np_hvc_iter.sv
// Directed bench for np_hvc_iter: vector table plus reset, backpressure and back-to-back sequences.
module tb_np_hvc_iter;
    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid, in_ready, out_valid, out_ready, err_out;
    logic signed [31:0] x_in, y_in, z_in, x_out, y_out, z_out;

    int passed = 0;
    int total  = 0;

`ifdef HVC_GAIN_COMP_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif
    localparam int LAT_OK = GC ? 20 : 19;

    always #5 clk = ~clk;

    np_hvc_iter dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .err_out(err_out)
    );

    task automatic chk(input string nm, input longint act, input longint exp, input longint tol);
        longint d;
        d = act - exp;
        if (d < 0) d = -d;
        total++;
        if (d > tol) $display("FAIL %s: got %0d want %0d (tol %0d)", nm, act, exp, tol);
        else passed++;
    endtask

    // Present one operand set, return edges from accept edge (=1) until out_valid is seen.
    task automatic op(input logic signed [31:0] xa, input logic signed [31:0] ya,
                      input logic signed [31:0] za, output int lat);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1, 0);
        x_in = xa; y_in = ya; z_in = za; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", out_valid, 0, 0);
        chk("release_ready", in_ready, 1, 0);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic signed [31:0] x, y, z;
        bit                 err;
        longint             ex, ey, ez, tol;
    } vec_t;

    vec_t vt [10];

    initial begin
        int lat, gap;
        vt[0] = '{32'sd65536,  32'sd32768,  32'sd0,    1'b0, GC ? 56756 : 47003,   0, 35999,  8};
        vt[1] = '{32'sd65536,  32'sd0,      32'sd1000, 1'b0, GC ? 65536 : 54274,   0, 1000,   8};
        vt[2] = '{-32'sd65536, 32'sd0,      32'sd0,    1'b1, 0,                    0, 0,      0};
        vt[3] = '{32'sd65536,  32'sd65536,  32'sd0,    1'b1, 0,                    0, 0,      0};
        vt[4] = '{32'sd65536,  -32'sd32768, 32'sd0,    1'b0, GC ? 56756 : 47003,   0, -35999, 8};
        vt[5] = '{32'sd0,      32'sd0,      32'sd0,    1'b1, 0,                    0, 0,      0};
        vt[6] = '{32'sd131072, 32'sd65536,  32'sd0,    1'b0, GC ? 113512 : 94006,  0, 35999,  16};
        vt[7] = '{32'sd65536,  -32'sd65536, 32'sd0,    1'b1, 0,                    0, 0,      0};
        vt[8] = '{32'sd65536,  32'h80000000, 32'sd0,   1'b1, 0,                    0, 0,      0};
        vt[9] = '{32'sd65536,  32'sd0,      -32'sd5000, 1'b0, GC ? 65536 : 54274,  0, -5000,  8};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1, 0);
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_x", x_out, 0, 0);
        chk("rst_z", z_out, 0, 0);
        chk("rst_err", err_out, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            op(vt[v].x, vt[v].y, vt[v].z, lat);
            chk($sformatf("v%0d_latency", v), lat, vt[v].err ? 1 : LAT_OK, 0);
            chk($sformatf("v%0d_err", v), err_out, vt[v].err, 0);
            chk($sformatf("v%0d_x", v), x_out, vt[v].ex, vt[v].tol);
            chk($sformatf("v%0d_y", v), y_out, vt[v].ey, vt[v].tol);
            chk($sformatf("v%0d_z", v), z_out, vt[v].ez, vt[v].tol);
            chk($sformatf("v%0d_in_ready", v), in_ready, 0, 0);
            release_out();
        end

        // Backpressure: result held while new operands are offered and refused.
        op(32'sd65536, 32'sd32768, 32'sd0, lat);
        chk("bp_latency", lat, LAT_OK, 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            x_in = 32'sd65536; y_in = 32'sd0; z_in = 32'sd777; in_valid = 1'b1;
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1, 0);
            chk("bp_in_ready", in_ready, 0, 0);
            chk("bp_x", x_out, GC ? 56756 : 47003, 8);
            chk("bp_z", z_out, 35999, 8);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();

        // Reset at step 5 abandons the operation; outputs clear without a clock edge.
        @(negedge clk);
        x_in = 32'sd65536; y_in = 32'sd0; z_in = 32'sd1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0, 0);
        chk("mid_rst_ready", in_ready, 1, 0);
        chk("mid_rst_x", x_out, 0, 0);
        chk("mid_rst_z", z_out, 0, 0);
        chk("mid_rst_err", err_out, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        op(32'sd65536, -32'sd32768, 32'sd0, lat);
        chk("post_rst_latency", lat, LAT_OK, 0);
        chk("post_rst_z", z_out, -35999, 8);
        release_out();

        // Back-to-back with out_ready held high.
        @(negedge clk);
        x_in = 32'sd65536; y_in = 32'sd32768; z_in = 32'sd0;
        in_valid = 1'b1; out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 60);
        chk("b2b_first_latency", lat, LAT_OK, 0);
        chk("b2b_first_z", z_out, 35999, 8);
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (!out_valid && gap < 60);
        chk("b2b_gap", gap, LAT_OK + 1, 0);
        chk("b2b_second_z", z_out, 35999, 8);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_final_ready", in_ready, 1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
